// File: rtl/scroll_pkg.sv
// rtl/scroll_pkg.sv - shared constants and debounce state encoding for the scroll step generator
package scroll_pkg;

    typedef enum logic [1:0] {
        DB_IDLE         = 2'd0,
        DB_PRESS_WAIT   = 2'd1,
        DB_PRESSED      = 2'd2,
        DB_RELEASE_WAIT = 2'd3
    } db_state_e;

    // 10 ms of stability at 50 MHz before a key edge is believed
    localparam int unsigned DEF_DB_CYCLES = 500000;
    // 8 Hz auto-scroll at 50 MHz for the fastest rate
    localparam int unsigned DEF_BASE_DIV  = 6250000;
    localparam int unsigned DEF_CNT_W     = 8;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - key_n synchroniser and debounce FSM producing a single press pulse
module key_debounce
    import scroll_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_pulse,
    output logic key_level
);

    localparam int unsigned DB_W = $clog2(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [1:0]      sync_q, sync_d;
    db_state_e       state_q, state_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            key_level_q, key_level_d;
    logic            key_s;

    // key_s is 0 while the button is held (active-low, like the raw key)
    assign key_s       = sync_q[1];
    assign key_level   = key_level_q;

    // State registers; synchroniser resets to the released level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            state_q     <= DB_IDLE;
            db_cnt_q    <= '0;
            key_level_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            key_level_q <= key_level_d;
        end
    end

    // Next-state logic; the press pulse is issued on the PRESS_WAIT -> PRESSED transition
    always_comb begin
        sync_d      = {sync_q[0], key_n};
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        press_pulse = 1'b0;
        case (state_q)
            DB_IDLE: begin
                if (!key_s) begin
                    state_d  = DB_PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end
            DB_PRESS_WAIT: begin
                if (key_s) begin
                    state_d = DB_IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = DB_PRESSED;
                    press_pulse = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            DB_PRESSED: begin
                if (key_s) begin
                    state_d  = DB_RELEASE_WAIT;
                    db_cnt_d = '0;
                end
            end
            DB_RELEASE_WAIT: begin
                if (!key_s) begin
                    state_d = DB_PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = DB_IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: state_d = DB_IDLE;
        endcase
        key_level_d = (state_d == DB_PRESSED) || (state_d == DB_RELEASE_WAIT);
    end

endmodule

// File: rtl/scroll_step_gen.sv
// rtl/scroll_step_gen.sv - merges debounced key presses and auto-scroll ticks into a one-cycle step enable
module scroll_step_gen
    import scroll_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
    parameter int unsigned BASE_DIV  = DEF_BASE_DIV,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_n,
    input  logic             auto_en,
    input  logic [1:0]       rate_sel,
    output logic             step,
    output logic             key_level,
    output logic [CNT_W-1:0] step_count
);

    localparam int unsigned PRE_W = $clog2(BASE_DIV << 3);
    localparam logic [PRE_W-1:0] P_LAST0 = PRE_W'(BASE_DIV - 1);
    localparam logic [PRE_W-1:0] P_LAST1 = PRE_W'((BASE_DIV << 1) - 1);
    localparam logic [PRE_W-1:0] P_LAST2 = PRE_W'((BASE_DIV << 2) - 1);
    localparam logic [PRE_W-1:0] P_LAST3 = PRE_W'((BASE_DIV << 3) - 1);

    logic [1:0]       rst_sync_q, rst_sync_d;
    logic             rst_n;
    logic             press_pulse;
    logic             auto_en_q, auto_en_d;
    logic [1:0]       rate_sel_q, rate_sel_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             step_q, step_d;
    logic [CNT_W-1:0] step_count_q, step_count_d;
    logic [PRE_W-1:0] p_last;
    logic             restart;
    logic             auto_pulse;

    assign rst_n      = rst_sync_q[1];
    assign step       = step_q;
    assign step_count = step_count_q;

    // Reset asserts immediately but is released two clocks later, in step with clk
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    key_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_key_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .press_pulse(press_pulse),
        .key_level  (key_level)
    );

    // Prescaler, control shadows, step and step counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_en_q    <= 1'b0;
            rate_sel_q   <= 2'd0;
            pre_cnt_q    <= '0;
            step_q       <= 1'b0;
            step_count_q <= '0;
        end else begin
            auto_en_q    <= auto_en_d;
            rate_sel_q   <= rate_sel_d;
            pre_cnt_q    <= pre_cnt_d;
            step_q       <= step_d;
            step_count_q <= step_count_d;
        end
    end

    // Prescaler restart/terminal count and merge of the two step sources
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
        auto_en_d  = auto_en;
        rate_sel_d = rate_sel;
        auto_pulse = 1'b0;
        pre_cnt_d  = pre_cnt_q;
        case (rate_sel_q)
            2'd0:    p_last = P_LAST0;
            2'd1:    p_last = P_LAST1;
            2'd2:    p_last = P_LAST2;
            default: p_last = P_LAST3;
        endcase
        restart = (auto_en && !auto_en_q) || (rate_sel != rate_sel_q) || press_pulse;
        if (!auto_en || restart) begin
            pre_cnt_d = '0;
        end else if (pre_cnt_q == p_last) begin
            auto_pulse = 1'b1;
            pre_cnt_d  = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end
        // A source firing right after a step is folded into that step so step never repeats back to back
        step_d       = (press_pulse || auto_pulse) && !step_q;
        step_count_d = step_d ? step_count_q + CNT_W'(1) : step_count_q;
    end

endmodule
